ripple_adder_4bit: RTL and testbench
====================================

# ripple_adder_4bit

Registered 4-bit ripple-carry adder that adds two unsigned operands and a carry-in, producing a 4-bit sum and carry-out. The sum is computed through a chain of four full-adder cells and captured in an output register. It is a leaf arithmetic block used wherever a small, area-cheap adder with a registered result is needed.

## Interface

Parameters:
- WIDTH, default 4: operand width; the block is verified only at 4.

Ports:
- clk, input, 1: single clock; all state updates on its rising edge.
- rst_n, input, 1: asynchronous, active-low reset.
- a, input, WIDTH: operand A, unsigned.
- b, input, WIDTH: operand B, unsigned.
- cin, input, 1: carry into bit 0.
- in_valid, input, 1: operands and cin are valid this cycle.
- sum, output, WIDTH: registered sum bits, a+b+cin mod 2^WIDTH.
- cout, output, 1: registered carry out of the MSB.
- out_valid, output, 1: sum and cout hold a new result this cycle.

## Operation

- Combinational chain: bit i uses a full adder (s_i = a_i ^ b_i ^ c_i; c_{i+1} = a_i&b_i | a_i&c_i | b_i&c_i), with c_0 = cin and cout = c_WIDTH.
- No lookahead: carry ripples bit 0 to bit WIDTH-1.
- {cout, sum} = a + b + cin exactly. The result is (WIDTH+1) bits wide, with no saturation and no signed interpretation.
- When in_valid=1 on a rising clk: sum and cout load the chain result and out_valid is set to 1.
- When in_valid=0 on a rising clk: sum and cout hold their previous values and out_valid is set to 0.
- No backpressure: every valid input produces exactly one result.

## Timing

- Latency is 1 cycle: a result for operands sampled at edge N is visible after edge N.
- Throughput is one operation per cycle, with back-to-back valids allowed.
- Reset: while rst_n=0, sum=0, cout=0 and out_valid=0, applied immediately regardless of clk.
- Reset asserted mid-operation discards the pending result.
- The first valid input is accepted on the first rising edge after rst_n deasserts.
- The combinational path a/b/cin to register is WIDTH full-adder carry delays and must close at the target clock.

## Structure

- Shared package ripple_adder_pkg holds localparam ADDER_WIDTH = 4, used as the WIDTH default.
- Sub-module full_adder (inputs a, b, cin; outputs s, cout; purely combinational) is instantiated WIDTH times via generate.
- The top level contains only the carry chain wiring and the output/valid registers.

## Test plan

Each case drives cin=0 and in_valid=1, and the check is made one cycle later:

- a=5, b=9 -> sum=1110, cout=0, out_valid=1.
- a=11, b=4 -> sum=1111, cout=0.
- a=15, b=9 -> sum=1000, cout=1 (overflow wrap).
- a=2, b=3 -> sum=0101, cout=0.

Additional directed cases:

- Carry-in and full ripple:
  - a=15, b=0, cin=1 -> sum=0000, cout=1.
  - a=15, b=15, cin=1 -> sum=1111, cout=1.
  - Exhaustive sweep of all 512 (a, b, cin) combinations is checked against a reference sum.
- Reset and valid:
  - Assert rst_n=0 between clock edges after a result is held -> sum=0, cout=0, out_valid=0 immediately.
  - in_valid=0 for 3 cycles -> outputs hold the last result, with out_valid=0.

Source files
------------

// File: rtl/ripple_adder_pkg.sv
// Shared constants for the registered ripple-carry adder.
package ripple_adder_pkg;
   localparam int ADDER_WIDTH = 4;
endpackage

// File: rtl/full_adder.sv
// One-bit full adder cell; the carry-chain building block of the ripple adder.
module full_adder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic cout
);
   assign s    = a ^ b ^ cin;
   assign cout = (a & b) | (a & cin) | (b & cin);
endmodule

// File: rtl/ripple_adder_4bit.sv
// Registered ripple-carry adder: {cout, sum} = a + b + cin, one cycle latency.
module ripple_adder_4bit
   import ripple_adder_pkg::*;
#(
   parameter int WIDTH = ADDER_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             in_valid,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             out_valid
);
   // Handshake: in_valid qualifies a/b/cin at a rising edge; out_valid is high
   // for exactly one cycle per accepted operand set. There is no ready signal.
   logic [WIDTH:0]   carry;
   logic [WIDTH-1:0] chain_sum;

   assign carry[0] = cin;

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      full_adder u_fa (
         .a    (a[i]),
         .b    (b[i]),
         .cin  (carry[i]),
         .s    (chain_sum[i]),
         .cout (carry[i+1])
      );
   end

   // Result registers hold their value while idle; only out_valid drops.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sum       <= '0;
         cout      <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         out_valid <= in_valid;
         if (in_valid) begin
            sum  <= chain_sum;
            cout <= carry[WIDTH];
         end
      end
   end
endmodule

// File: tb/tb_ripple_adder_4bit.sv
// Self-checking bench for ripple_adder_4bit against an arithmetic reference model.
module tb_ripple_adder_4bit;
   localparam int W = 4;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [W-1:0] a, b, sum;
   logic         cin, in_valid, cout, out_valid;

   int           total = 0;
   int           bad = 0;
   logic [W:0]   exp_q[$];
   logic [W:0]   last_res;

   always #5 clk = ~clk;

   ripple_adder_4bit #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .in_valid  (in_valid),
      .sum       (sum),
      .cout      (cout),
      .out_valid (out_valid)
   );

   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [W:0] ref_add(input int x, input int y, input int ci);
      int r;
      r = x + y + ci;
      return r[W:0];
   endfunction

   // Drive one cycle at the falling edge, then check 1 time unit after the rising edge.
   task automatic drive_op(input string tag, input int x, input int y, input int ci,
                           input bit vld);
      @(negedge clk);
      a = x[W-1:0];
      b = y[W-1:0];
      cin = ci[0];
      in_valid = vld;
      if (vld) exp_q.push_back(ref_add(x, y, ci));
      @(posedge clk);
      #1;
      if (vld) last_res = exp_q.pop_front();
      check({tag, "_valid"}, {7'd0, out_valid}, {7'd0, vld});
      check({tag, "_result"}, {3'd0, cout, sum}, {3'd0, last_res});
   endtask

   initial begin
      rst_n = 1'b0;
      a = '0; b = '0; cin = 1'b0; in_valid = 1'b0;
      last_res = '0;
      #2;
      check("reset_state", {2'd0, out_valid, cout, sum}, 8'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // Test plan directed cases, also checked against literal results.
      drive_op("tp_5_9", 5, 9, 0, 1'b1);
      check("tp_5_9_lit", {3'd0, cout, sum}, 8'b0_1110);
      drive_op("tp_11_4", 11, 4, 0, 1'b1);
      check("tp_11_4_lit", {3'd0, cout, sum}, 8'b0_1111);
      drive_op("tp_15_9", 15, 9, 0, 1'b1);
      check("tp_15_9_lit", {3'd0, cout, sum}, 8'b1_1000);
      drive_op("tp_2_3", 2, 3, 0, 1'b1);
      check("tp_2_3_lit", {3'd0, cout, sum}, 8'b0_0101);
      drive_op("cin_15_0", 15, 0, 1, 1'b1);
      check("cin_15_0_lit", {3'd0, cout, sum}, 8'b1_0000);
      drive_op("cin_15_15", 15, 15, 1, 1'b1);
      check("cin_15_15_lit", {3'd0, cout, sum}, 8'b1_1111);

      // Idle cycles hold the last result with out_valid low.
      for (int i = 0; i < 3; i++) drive_op("idle_hold", $urandom_range(0, 15),
                                           $urandom_range(0, 15), $urandom_range(0, 1), 1'b0);
      check("idle_lit", {2'd0, out_valid, cout, sum}, 8'b0_1_1111);

      // Asynchronous reset between edges clears everything immediately.
      drive_op("pre_reset", 9, 8, 1, 1'b1);
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_reset", {2'd0, out_valid, cout, sum}, 8'd0);
      // A valid operand presented during reset must be discarded.
      a = 4'd7; b = 4'd7; cin = 1'b1; in_valid = 1'b1;
      @(posedge clk);
      #1;
      check("reset_discard", {2'd0, out_valid, cout, sum}, 8'd0);
      @(negedge clk);
      in_valid = 1'b0;
      rst_n = 1'b1;
      last_res = '0;
      drive_op("first_after_reset", 6, 12, 1, 1'b1);

      // Exhaustive back-to-back sweep.
      for (int x = 0; x < 16; x++)
         for (int y = 0; y < 16; y++)
            for (int ci = 0; ci < 2; ci++)
               drive_op("sweep", x, y, ci, 1'b1);

      // Random operands with random idle gaps.
      for (int i = 0; i < 300; i++)
         drive_op("rand", $urandom_range(0, 15), $urandom_range(0, 15),
                  $urandom_range(0, 1), $urandom_range(0, 3) != 0);

      check("queue_empty", 8'(exp_q.size()), 8'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
